// File: rtl/shift_pkg.sv
// Shared op-code/state enums and default width for the shift register block.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that move one bit per step and may be repeated by a multi-step start.
  function automatic logic is_shift(input op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
           (o == OP_ROR) || (o == OP_ASR);
  endfunction

endpackage

// File: rtl/shreg_step.sv
// One shift/rotate step: purely combinational next value and shifted-out bit.
// LOAD is resolved by the caller (needs d); HOLD/LOAD pass q through.
module shreg_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             i,
  output logic [WIDTH-1:0] q_next,
  output logic             so_next
);

  always_comb begin
    q_next  = q;
    so_next = 1'b0;
    case (op)
      OP_SHL: begin q_next = {q[WIDTH-2:0], i};        so_next = q[WIDTH-1]; end
      OP_SHR: begin q_next = {i, q[WIDTH-1:1]};        so_next = q[0];       end
      OP_ROL: begin q_next = {q[WIDTH-2:0], q[WIDTH-1]}; so_next = q[WIDTH-1]; end
      OP_ROR: begin q_next = {q[0], q[WIDTH-1:1]};     so_next = q[0];       end
      OP_ASR: begin q_next = {q[WIDTH-1], q[WIDTH-1:1]}; so_next = q[0];     end
      OP_CLR: q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_register_n.sv
// Universal shift register with single-cycle ops and amt-step shifts (one step/cycle).
// Final value and one-cycle done appear together; inputs other than i are ignored while busy.
module shift_register_n
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             i,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  logic [WIDTH-1:0] q_step;
  logic             so_step;

  assign op_in   = op_e'(op);
  assign step_op = (state_q == ST_RUN) ? op_q : op_in;

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .op      (step_op),
    .i       (i),
    .q_next  (q_step),
    .so_next (so_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && is_shift(op_in)) begin
          if (amt != '0) begin
            q_d   = q_step;
            so_d  = so_step;
            op_d  = op_in;
            rem_d = amt - CNT_W'(1);
            if (amt == CNT_W'(1)) done_d  = 1'b1;
            else                  state_d = ST_RUN;
          end else begin
            // Zero-step launch: nothing moves, but the requester still gets its done.
            done_d = 1'b1;
          end
        end else begin
          q_d = (op_in == OP_LOAD) ? d : q_step;
          if (is_shift(op_in)) so_d = so_step;
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        so_d  = so_step;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so   = so_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Scoreboarded bench: driver pushes model-predicted outputs per edge, monitor pops/compares at negedge.
module tb_shift_register_n;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [2:0] op;
  logic [7:0] d;
  logic       i;
  logic       start;
  logic [3:0] amt;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];

  // Reference model state
  int   m_q;
  logic m_so;
  logic m_busy;
  logic m_done;
  int   m_op;
  int   m_left;

  shift_register_n dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .d     (d),
    .i     (i),
    .start (start),
    .amt   (amt),
    .q     (q),
    .so    (so),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic shift_op(input int o);
    return (o == 1) || (o == 2) || (o == 4) || (o == 5) || (o == 6);
  endfunction

  // One step in arithmetic form: updates m_q and m_so.
  task automatic model_one(input int o, input int si);
    case (o)
      1: begin m_so = (m_q / 128) != 0; m_q = (m_q * 2 + si) % 256; end
      2: begin m_so = (m_q % 2) != 0;   m_q = m_q / 2 + si * 128; end
      4: begin m_so = (m_q / 128) != 0; m_q = (m_q * 2) % 256 + m_q / 128; end
      5: begin m_so = (m_q % 2) != 0;   m_q = m_q / 2 + (m_q % 2) * 128; end
      6: begin m_so = (m_q % 2) != 0;   m_q = m_q / 2 + (m_q / 128) * 128; end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic r, input int o, input int dd, input int si,
                            input logic st, input int a);
    m_done = 1'b0;
    if (r) begin
      m_q = 0; m_so = 1'b0; m_busy = 1'b0; m_left = 0;
    end else if (m_busy) begin
      model_one(m_op, si);
      m_left = m_left - 1;
      if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
    end else if (st && shift_op(o)) begin
      if (a == 0) m_done = 1'b1;
      else begin
        model_one(o, si);
        if (a == 1) m_done = 1'b1;
        else begin m_busy = 1'b1; m_left = a - 1; m_op = o; end
      end
    end else begin
      if (o == 3) m_q = dd;
      else if (o == 7) m_q = 0;
      else model_one(o, si);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] o, input logic [7:0] dd,
                     input logic si, input logic st, input logic [3:0] a);
    rst = r; op = o; d = dd; i = si; start = st; amt = a;
    @(posedge clk);
    model_edge(r, int'(o), int'(dd), int'(si), st, int'(a));
    exp_q.push_back({8'(m_q), m_so, m_busy, m_done});
    #1;
  endtask

  task automatic junk_cyc();
    cyc(1'b0, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'($urandom_range(1)),
        1'($urandom_range(1)), 4'($urandom_range(15)));
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents q/so/busy/done; compare against the scoreboard.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({q, so, busy, done} !== e) begin
          errors++;
          $display("FAIL sb: got q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                   q, so, busy, done, e[10:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    m_q = 0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_op = 0; m_left = 0;

    // Reset from arbitrary inputs
    cyc(1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 4'd5);
    cyc(1'b1, 3'd1, 8'h5A, 1'b1, 1'b1, 4'd3);
    chk("rst_q", int'(q), 0);
    chk("rst_busy_done", int'({busy, done, so}), 0);

    // LOAD then SHL
    cyc(1'b0, 3'd3, 8'hB4, 1'b0, 1'b0, 4'd0);
    chk("load_q", int'(q), 'hB4);
    cyc(1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("shl_q", int'(q), 'h69);
    chk("shl_so", int'(so), 1);

    // Multi-step ASR, amt=3
    cyc(1'b0, 3'd3, 8'h80, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 3'd6, 8'h00, 1'b0, 1'b1, 4'd3);
    chk("asr1_q", int'(q), 'hC0);
    chk("asr1_busy", int'(busy), 1);
    junk_cyc();
    chk("asr2_q", int'(q), 'hE0);
    junk_cyc();
    chk("asr3_q", int'(q), 'hF0);
    chk("asr3_done_busy_so", int'({done, busy, so}), 3'b100);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("asr_done_once", int'(done), 0);

    // Full rotate, ROL x8, with garbage on op/d/start during RUN
    cyc(1'b0, 3'd3, 8'hA5, 1'b0, 1'b0, 4'd0);
    busy_cnt = 0;
    cyc(1'b0, 3'd4, 8'h00, 1'b0, 1'b1, 4'd8);
    busy_cnt += int'(busy);
    for (int k = 0; k < 7; k++) begin
      junk_cyc();
      busy_cnt += int'(busy);
    end
    chk("rol8_q", int'(q), 'hA5);
    chk("rol8_done", int'(done), 1);
    chk("rol8_busy_cycles", busy_cnt, 7);

    // Zero-step start
    cyc(1'b0, 3'd3, 8'h3C, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 3'd1, 8'h00, 1'b1, 1'b1, 4'd0);
    chk("amt0_q", int'(q), 'h3C);
    chk("amt0_done_busy", int'({done, busy}), 2'b10);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("amt0_done_once", int'(done), 0);

    // Reset during the third RUN cycle of SHR amt=6
    cyc(1'b0, 3'd3, 8'hFF, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 4'd6);
    junk_cyc();
    junk_cyc();
    chk("shr_run3_busy", int'(busy), 1);
    cyc(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      done_cnt += int'(done);
    end
    chk("midrst_no_done", done_cnt, 0);

    // Randomized traffic, amt up to 15 exercises steps beyond WIDTH
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(39) == 0), 3'($urandom_range(7)), 8'($urandom_range(255)),
          1'($urandom_range(1)), 1'($urandom_range(2) == 0), 4'($urandom_range(15)));
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_register_n.md
SHIFT_REGISTER_N -- requirements
Module: shift_register_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits; legal values are 2 or more.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning the width of the step-count input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port op, input, 3 bits: operation code.
REQ-006 SHALL have port d, input, WIDTH bits: parallel load data.
REQ-007 SHALL have port i, input, 1 bit: serial input for SHL/SHR.
REQ-008 SHALL have port start, input, 1 bit: launch a multi-step shift.
REQ-009 SHALL have port amt, input, CNT_W bits: number of steps for a multi-step shift.
REQ-010 SHALL have port q, output, WIDTH bits: register contents.
REQ-011 SHALL have port so, output, 1 bit: bit shifted out by the most recent shift step.
REQ-012 SHALL have port busy, output, 1 bit: multi-step shift in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL decode op as follows: 000 HOLD; 001 SHL (q[k]<=q[k-1], q[0]<=i); 010 SHR (q[k]<=q[k+1], q[W-1]<=i); 011 LOAD (q<=d); 100 ROL; 101 ROR; 110 ASR (MSB kept, shift toward LSB); 111 CLR (q<=0).
REQ-015 SHALL set so on each step: q[W-1] pre-step for SHL/ROL, q[0] pre-step for SHR/ROR/ASR; so SHALL hold its value otherwise.
REQ-016 SHALL use two states, IDLE and RUN; busy SHALL equal (state==RUN).
REQ-017 SHALL, in IDLE with start=0, apply op to q once per cycle, with no done pulse.
REQ-018 SHALL, in IDLE with start=1 and op a shift/rotate code (001,010,100,101,110) and amt>0, perform step 1 at that edge, latch op, load remaining=amt-1, and enter RUN if amt>1, else stay IDLE with done<=1.
REQ-019 SHALL, in RUN, perform one step per cycle with the latched op, sampling i live each step, and decrement remaining; on the step where remaining==1 it SHALL go IDLE and set done<=1.
REQ-020 SHALL make the final value available in the same cycle as done; done SHALL be high for exactly one cycle.
REQ-021 SHALL treat start=1 with amt=0 as follows: q and so unchanged, done<=1 next cycle, busy never asserted.
REQ-022 SHALL treat start=1 with op HOLD/LOAD/CLR as the single-cycle op with start ignored: no RUN, no done.
REQ-023 SHALL ignore op, d, start and amt while in RUN; i is still sampled.
REQ-024 SHALL complete a multi-step shift of amt steps at edge E0+amt-1, where E0 is the start edge; busy is high for amt-1 cycles.
REQ-025 SHALL apply steps literally when amt>WIDTH; there is no saturation, so rotates wrap and shifts flush fully with i or the sign bit.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set q=0, so=0, done=0, state=IDLE and remaining=0 regardless of any other input.
REQ-027 SHALL abort on rst during RUN with no later done pulse.

Structure
REQ-028 SHALL place the op-code enum, the state enum (IDLE, RUN) and the default WIDTH constant in shared package shift_pkg.
REQ-029 SHALL implement the one-step next-value/so logic as a purely combinational sub-module shreg_step (inputs q, op, i; outputs q_next, so_next), shared by single-cycle and RUN paths.

Verification
REQ-030 SHALL cover reset: rst=1 from arbitrary state -> q=0x00, so=0, busy=0, done=0 the next cycle.
REQ-031 SHALL cover LOAD then SHL: LOAD d=0xB4 -> q=0xB4; then SHL with i=1 -> q=0x69, so=1.
REQ-032 SHALL cover multi-step ASR: q=0x80, start, op=ASR, amt=3 -> q=0xC0, 0xE0, 0xF0 on successive edges; busy high 2 cycles; done high 1 cycle with q=0xF0; so=0.
REQ-033 SHALL cover a full rotate: q=0xA5, start, op=ROL, amt=8 -> q=0xA5 at done; busy 7 cycles; op/d changes during RUN have no effect.
REQ-034 SHALL cover a zero-step start: start with amt=0, q=0x3C -> q stays 0x3C, done pulses once, busy stays 0.
REQ-035 SHALL cover reset mid-RUN: start SHR amt=6, assert rst in the 3rd RUN cycle -> q=0x00, busy=0 next cycle, no done pulse afterwards.
